wb_data_arbiter: RTL and testbench

Two-master Wishbone-classic arbiter that shares the single 8-bit data memory slave between the Gumnut core's data port (master 0) and a host/debug loader port (master 1). It sits between the core's data_cyc/stb/we/adr/dat signals and `DataMemory`. It grants the slave to one master per bus cycle using round-robin priority. A wait watchdog terminates accesses the slave never acknowledges, so neither master can hang the core.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arb_watchdog.sv | 33 +++
 rtl/wb_data_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_data_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and default sizing for the two-master data-memory arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam int ARB_AW      = 8;
   localparam int ARB_DW      = 8;
   localparam int ARB_TIMEOUT = 16;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Wait counter for the shared slave: pulses expire when a strobe has gone
// unacknowledged for TIMEOUT cycles. TIMEOUT of 0 disables it.
module wb_arb_watchdog
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic stb,
   input  logic ack,
   input  logic clr,
   output logic expire
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam bit ENABLED = (TIMEOUT > 0);

   logic [CW-1:0] wait_cnt;

   // Ack in the expiry cycle suppresses the error.
   assign expire = ENABLED && stb && !ack && (wait_cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (rst || clr || !stb || ack || expire || !ENABLED) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/wb_data_arbiter.sv
// Round-robin Wishbone-classic arbiter sharing DataMemory between the core
// data port (m0) and the loader (m1), with a watchdog on slave acknowledge.
module wb_data_arbiter
   import wb_arb_pkg::*;
#(
   parameter int AW      = ARB_AW,
   parameter int DW      = ARB_DW,
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   output logic [1:0]    grant_o
);

   arb_state_t state_q, state_d;
   logic       last_q, last_d;

   logic          own_cyc;
   logic          own_stb;
   logic          own_we;
   logic [AW-1:0] own_adr;
   logic [DW-1:0] own_dat;
   logic          raw_stb;
   logic          expire;
   logic          grant_change;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Ownership is held for the whole bus cycle; release hands straight over.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_d = GNT0;
            end else if (m1_cyc_i) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               last_d  = 1'b0;
               state_d = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               last_d  = 1'b1;
               state_d = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_adr = '0;
      own_dat = '0;
      case (state_q)
         GNT0: begin
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
            own_we  = m0_we_i;
            own_adr = m0_adr_i;
            own_dat = m0_dat_i;
         end
         GNT1: begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            own_we  = m1_we_i;
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
         end
         default: begin
            own_cyc = 1'b0;
         end
      endcase
   end

   assign raw_stb      = own_cyc & own_stb;
   assign grant_change = (state_d != state_q);

   wb_arb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk    (clk_i),
      .rst    (rst_i),
      .stb    (raw_stb),
      .ack    (s_ack_i),
      .clr    (grant_change),
      .expire (expire)
   );

   // An expiring strobe is withdrawn from the slave in the same cycle.
   assign s_cyc_o = own_cyc;
   assign s_stb_o = raw_stb & ~expire;
   assign s_we_o  = own_we;
   assign s_adr_o = own_adr;
   assign s_dat_o = own_dat;

   assign m0_ack_o = (state_q == GNT0) & s_ack_i;
   assign m1_ack_o = (state_q == GNT1) & s_ack_i;
   assign m0_err_o = (state_q == GNT0) & expire;
   assign m1_err_o = (state_q == GNT1) & expire;

   assign m0_dat_o = (state_q != IDLE) ? s_dat_i : '0;
   assign m1_dat_o = (state_q != IDLE) ? s_dat_i : '0;

   assign grant_o = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Bench for wb_data_arbiter: table of per-cycle vectors against a 1-cycle
// memory model, read data scoreboarded per master, plus watchdog/reset sequences.
module tb_wb_data_arbiter;

   typedef struct {
      logic       c0, s0, w0;
      logic [7:0] a0, d0;
      logic       c1, s1, w1;
      logic [7:0] a1, d1;
      logic [1:0] g;
      logic       k0, k1, sstb;
      logic       p0;
      logic [7:0] e0;
      logic       p1;
      logic [7:0] e1;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m0_cyc = 0, m0_stb = 0, m0_we = 0;
   logic [7:0] m0_adr = 0, m0_dat = 0;
   logic       m1_cyc = 0, m1_stb = 0, m1_we = 0;
   logic [7:0] m1_adr = 0, m1_dat = 0;
   logic [7:0] m0_dat_o, m1_dat_o;
   logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic       s_cyc_o, s_stb_o, s_we_o;
   logic [7:0] s_adr_o, s_dat_o;
   logic [1:0] grant_o;

   logic [7:0] mem [256];
   logic       mem_ack;
   logic [7:0] mem_dat;
   int         mem_ctr;
   bit         ack_en = 1'b1;
   int         ack_delay = 0;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   vec_t       vecs[$];

   always #5 clk = ~clk;

   wb_data_arbiter #(.AW(8), .DW(8), .TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(mem_dat), .s_ack_i(mem_ack),
      .grant_o(grant_o)
   );

   // DataMemory stand-in: registered ack after ack_delay extra strobe cycles.
   always @(posedge clk) begin
      if (rst) begin
         mem_ack <= 1'b0;
         mem_dat <= 8'h00;
         mem_ctr <= 0;
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
         mem[8'h10] <= 8'h5A;
      end else if (s_cyc_o && s_stb_o && !mem_ack) begin
         if (ack_en && mem_ctr == ack_delay) begin
            mem_ack <= 1'b1;
            mem_dat <= mem[s_adr_o];
            if (s_we_o) mem[s_adr_o] <= s_dat_o;
            mem_ctr <= 0;
         end else begin
            mem_ack <= 1'b0;
            mem_ctr <= mem_ctr + 1;
         end
      end else begin
         mem_ack <= 1'b0;
         mem_ctr <= 0;
      end
   end

   function automatic vec_t mk(
      input logic c0, s0, w0, input logic [7:0] a0, d0,
      input logic c1, s1, w1, input logic [7:0] a1, d1,
      input logic [1:0] g, input logic k0, k1, sstb,
      input logic p0, input logic [7:0] e0, input logic p1, input logic [7:0] e1);
      vec_t v;
      v.c0 = c0; v.s0 = s0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.c1 = c1; v.s1 = s1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g = g; v.k0 = k0; v.k1 = k1; v.sstb = sstb;
      v.p0 = p0; v.e0 = e0; v.p1 = p1; v.e1 = e1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic setM0(input logic c, s, w, input logic [7:0] a, d);
      m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat = d;
   endtask

   task automatic setM1(input logic c, s, w, input logic [7:0] a, d);
      m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat = d;
   endtask

   // Pops the scoreboard whenever a master sees a read acknowledged.
   task automatic checkAckData();
      if (m0_ack_o && !m0_we) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL m0_rdata actual=%0h required=none_pending", m0_dat_o);
         end else check("m0_rdata", 32'(m0_dat_o), 32'(q0.pop_front()));
      end
      if (m1_ack_o && !m1_we) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL m1_rdata actual=%0h required=none_pending", m1_dat_o);
         end else check("m1_rdata", 32'(m1_dat_o), 32'(q1.pop_front()));
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      setM0(v.c0, v.s0, v.w0, v.a0, v.d0);
      setM1(v.c1, v.s1, v.w1, v.a1, v.d1);
      if (v.p0) q0.push_back(v.e0);
      if (v.p1) q1.push_back(v.e1);
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      @(negedge clk);
      check($sformatf("grant[%0d]", idx), 32'(grant_o), 32'(v.g));
      check($sformatf("m0_ack[%0d]", idx), 32'(m0_ack_o), 32'(v.k0));
      check($sformatf("m1_ack[%0d]", idx), 32'(m1_ack_o), 32'(v.k1));
      check($sformatf("m0_err[%0d]", idx), 32'(m0_err_o), 0);
      check($sformatf("m1_err[%0d]", idx), 32'(m1_err_o), 0);
      check($sformatf("s_stb[%0d]", idx), 32'(s_stb_o), 32'(v.sstb));
      checkAckData();
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_grant"}, 32'(grant_o), 0);
      check({tag, "_s_cyc"}, 32'(s_cyc_o), 0);
      check({tag, "_s_stb"}, 32'(s_stb_o), 0);
      check({tag, "_s_we"}, 32'(s_we_o), 0);
      check({tag, "_s_adr"}, 32'(s_adr_o), 0);
      check({tag, "_s_dat"}, 32'(s_dat_o), 0);
      check({tag, "_acks"}, 32'({m0_ack_o, m1_ack_o}), 0);
      check({tag, "_errs"}, 32'({m0_err_o, m1_err_o}), 0);
      check({tag, "_m0_dat"}, 32'(m0_dat_o), 0);
      check({tag, "_m1_dat"}, 32'(m1_dat_o), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL sim_timeout actual=running required=finished");
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      // Same-edge tie after reset: m0 writes 0x33 to 0x20, m1 then reads it back.
      vecs.push_back(mk(1,1,1,8'h20,8'h33, 1,1,0,8'h20,8'h00, 2'b00,0,0,0, 0,8'h00,1,8'h33));
      vecs.push_back(mk(1,1,1,8'h20,8'h33, 1,1,0,8'h20,8'h00, 2'b01,0,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,1,8'h20,8'h33, 1,1,0,8'h20,8'h00, 2'b01,1,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h20,8'h00, 2'b01,0,0,0, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h20,8'h00, 2'b10,0,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h20,8'h00, 2'b10,0,1,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b10,0,0,0, 0,8'h00,0,8'h00));
      // Both requesting with single-access cycles: grants alternate.
      vecs.push_back(mk(1,1,0,8'h01,8'h00, 1,1,0,8'h02,8'h00, 2'b00,0,0,0, 1,8'hA4,1,8'hA7));
      vecs.push_back(mk(1,1,0,8'h01,8'h00, 1,1,0,8'h02,8'h00, 2'b01,0,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h01,8'h00, 1,1,0,8'h02,8'h00, 2'b01,1,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h02,8'h00, 2'b01,0,0,0, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h03,8'h00, 1,1,0,8'h02,8'h00, 2'b10,0,0,1, 1,8'hA6,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h03,8'h00, 1,1,0,8'h02,8'h00, 2'b10,0,1,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h03,8'h00, 0,0,0,8'h00,8'h00, 2'b10,0,0,0, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h03,8'h00, 1,1,0,8'h04,8'h00, 2'b01,0,0,1, 0,8'h00,1,8'hA1));
      vecs.push_back(mk(1,1,0,8'h03,8'h00, 1,1,0,8'h04,8'h00, 2'b01,1,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h04,8'h00, 2'b01,0,0,0, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h04,8'h00, 2'b10,0,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h04,8'h00, 2'b10,0,1,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b10,0,0,0, 0,8'h00,0,8'h00));
      // m0 single read of 0x10.
      vecs.push_back(mk(1,1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 2'b00,0,0,0, 1,8'h5A,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 2'b01,0,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 2'b01,1,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b01,0,0,0, 0,8'h00,0,8'h00));
      // m1 keeps cyc over three strobes while m0 waits.
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'h05,8'h00, 2'b00,0,0,0, 0,8'h00,1,8'hA0));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 1,1,0,8'h05,8'h00, 2'b10,0,0,1, 1,8'hA3,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 1,1,0,8'h05,8'h00, 2'b10,0,1,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 1,1,0,8'h07,8'h00, 2'b10,0,0,1, 0,8'h00,1,8'hA2));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 1,1,0,8'h07,8'h00, 2'b10,0,1,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 1,1,0,8'h08,8'h00, 2'b10,0,0,1, 0,8'h00,1,8'hAD));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 1,1,0,8'h08,8'h00, 2'b10,0,1,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 0,0,0,8'h00,8'h00, 2'b10,0,0,0, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 0,0,0,8'h00,8'h00, 2'b01,0,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(1,1,0,8'h06,8'h00, 0,0,0,8'h00,8'h00, 2'b01,1,0,1, 0,8'h00,0,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 2'b01,0,0,0, 0,8'h00,0,8'h00));

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end

      // Slave never acks: error on the fifth strobe cycle, strobe withdrawn.
      ack_en = 1'b0;
      @(posedge clk); #1;
      setM0(1, 1, 0, 8'h30, 8'h00);
      @(negedge clk);
      check("wd_idle_grant", 32'(grant_o), 0);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check($sformatf("wd_err[%0d]", i), 32'(m0_err_o), 32'(i == 5));
         check($sformatf("wd_stb[%0d]", i), 32'(s_stb_o), 32'(i != 5));
         check($sformatf("wd_ack[%0d]", i), 32'({m0_ack_o, m1_ack_o}), 0);
         check($sformatf("wd_m1_err[%0d]", i), 32'(m1_err_o), 0);
         check($sformatf("wd_grant[%0d]", i), 32'(grant_o), 32'(2'b01));
      end
      @(posedge clk); #1;
      setM0(0, 0, 0, 8'h00, 8'h00);
      @(negedge clk);

      // Ack lands exactly in the expiry cycle: ack wins.
      ack_en = 1'b1;
      ack_delay = 3;
      @(posedge clk); #1;
      setM0(1, 1, 0, 8'h31, 8'h00);
      q0.push_back(8'h94);
      @(negedge clk);
      check("late_idle_grant", 32'(grant_o), 0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("late_ack[%0d]", i), 32'(m0_ack_o), 32'(i == 5));
         check($sformatf("late_err[%0d]", i), 32'(m0_err_o), 0);
         check($sformatf("late_stb[%0d]", i), 32'(s_stb_o), 1);
         checkAckData();
      end
      @(posedge clk); #1;
      setM0(0, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      ack_delay = 0;

      // Reset pulsed while m1 is strobing a write.
      ack_en = 1'b0;
      @(posedge clk); #1;
      setM1(1, 1, 1, 8'h44, 8'h77);
      @(negedge clk);
      @(negedge clk);
      check("g1_grant", 32'(grant_o), 32'(2'b10));
      check("g1_s_stb", 32'(s_stb_o), 1);
      check("g1_s_we", 32'(s_we_o), 1);
      check("g1_s_adr", 32'(s_adr_o), 32'h44);
      check("g1_s_dat", 32'(s_dat_o), 32'h77);
      rst = 1'b1;
      @(negedge clk);
      checkAllZero("midrst");
      rst = 1'b0;
      setM1(0, 0, 0, 8'h00, 8'h00);
      ack_en = 1'b1;
      @(negedge clk);
      check("post_rst_grant", 32'(grant_o), 0);

      check("q0_drained", 32'(q0.size()), 0);
      check("q1_drained", 32'(q1.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
